// File: rtl/regfile_write_arbiter.sv
// Owns the register file write port: zero-fills all registers after reset, then
// arbitrates ALU (A) and load (B) write-backs onto a registered one-hot write bus.
module regfile_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [4:0]        a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [4:0]        b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic [NREG-1:0]   wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              zero_drop,
  output logic              clearing
);

  localparam int AW = 5;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t ST_INIT = CLEAR_EN ? ST_CLEAR : ST_RUN;
  localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

  state_t              state_r, state_nxt_s;
  logic [AW-1:0]       cnt_r, cnt_nxt_s;
  logic                prio_b_r, prio_b_nxt_s;
  logic                clearing_r;
  logic                grant_a_s, grant_b_s;
  logic [AW-1:0]       acc_addr_s;
  logic [DATA_W-1:0]   acc_data_s;
  logic [NREG-1:0]     wr_en_r, wr_en_nxt_s;
  logic [AW-1:0]       wr_addr_r, wr_addr_nxt_s;
  logic [DATA_W-1:0]   wr_data_r, wr_data_nxt_s;
  logic                zero_drop_r, zero_drop_nxt_s;

  function automatic logic [NREG-1:0] decode(input logic [AW-1:0] addr);
    logic [NREG-1:0] onehot;
    onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      onehot[i] = (addr == AW'(i));
    end
    return onehot;
  endfunction

  // Next-state, arbitration and write-bus selection
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    prio_b_nxt_s    = prio_b_r;
    grant_a_s       = 1'b0;
    grant_b_s       = 1'b0;
    acc_addr_s      = a_addr;
    acc_data_s      = a_data;
    wr_en_nxt_s     = '0;
    wr_addr_nxt_s   = wr_addr_r;
    wr_data_nxt_s   = wr_data_r;
    zero_drop_nxt_s = 1'b0;

    case (state_r)
      ST_CLEAR: begin
        wr_en_nxt_s   = decode(cnt_r);
        wr_addr_nxt_s = cnt_r;
        wr_data_nxt_s = '0;
        cnt_nxt_s     = cnt_r + 5'd1;
        if (cnt_r == LAST_REG) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_RUN: begin
        // clearing_r covers the cycle where the last clear write is still on the bus
        if (clearing_r) begin
          grant_a_s = 1'b0;
          grant_b_s = 1'b0;
        end else if (a_valid && b_valid) begin
          grant_a_s    = !prio_b_r;
          grant_b_s    = prio_b_r;
          prio_b_nxt_s = !prio_b_r;
        end else begin
          grant_a_s = a_valid;
          grant_b_s = b_valid;
        end

        if (grant_b_s) begin
          acc_addr_s = b_addr;
          acc_data_s = b_data;
        end else begin
          acc_addr_s = a_addr;
          acc_data_s = a_data;
        end

        if (grant_a_s || grant_b_s) begin
          wr_data_nxt_s = acc_data_s;
          if (acc_addr_s == 5'd0) begin
            wr_en_nxt_s     = '0;
            wr_addr_nxt_s   = 5'd0;
            zero_drop_nxt_s = 1'b1;
          end else begin
            wr_en_nxt_s   = decode(acc_addr_s);
            wr_addr_nxt_s = acc_addr_s;
          end
        end else begin
          wr_en_nxt_s = '0;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
        cnt_nxt_s   = 5'd0;
      end
    endcase
  end

  // Control state: FSM, clear counter and arbitration priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_INIT;
      cnt_r    <= 5'd0;
      prio_b_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      prio_b_r <= prio_b_nxt_s;
    end
  end

  // Registered write bus and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_r     <= '0;
      wr_addr_r   <= 5'd0;
      wr_data_r   <= '0;
      zero_drop_r <= 1'b0;
      clearing_r  <= CLEAR_EN;
    end else begin
      wr_en_r     <= wr_en_nxt_s;
      wr_addr_r   <= wr_addr_nxt_s;
      wr_data_r   <= wr_data_nxt_s;
      zero_drop_r <= zero_drop_nxt_s;
      clearing_r  <= (state_r == ST_CLEAR);
    end
  end

  assign a_ready   = grant_a_s;
  assign b_ready   = grant_b_s;
  assign wr_en     = wr_en_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign zero_drop = zero_drop_r;
  assign clearing  = clearing_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued at grant
// time from a behavioural arbitration model and popped when the write bus fires.
module tb_regfile_write_arbiter;

  typedef struct {
    logic [31:0] en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        zd;
  } exp_t;

  logic        clk, rst_n;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_addr, b_addr, wr_addr;
  logic [31:0] a_data, b_data, wr_data, wr_en;
  logic        zero_drop, clearing;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // model state and driver-side request registers
  bit          a_first;
  bit          last_ga, last_gb;
  bit          av, bv;
  logic [4:0]  aa, ba;
  logic [31:0] ad, bd;

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .zero_drop(zero_drop), .clearing(clearing)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_write(input logic [4:0] addr, input logic [31:0] data);
    exp_t e;
    e.data = data;
    if (addr == 5'd0) begin
      e.en = 32'h0; e.addr = 5'd0; e.zd = 1'b1;
    end else begin
      e.en = 32'h1 << addr; e.addr = addr; e.zd = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic push_clear();
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      e.en = 32'h1 << k; e.addr = 5'(k); e.data = 32'h0; e.zd = 1'b0;
      sb.push_back(e);
    end
  endtask

  // One RUN cycle: drive requests, check grants against the model, queue the write
  task automatic cyc();
    bit ga, gb;
    @(posedge clk); #1;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #3;
    ga = av && (!bv || a_first);
    gb = bv && (!av || !a_first);
    check("a_ready", a_ready, ga);
    check("b_ready", b_ready, gb);
    if (av && bv) a_first = gb;
    if (ga) push_write(aa, ad);
    else if (gb) push_write(ba, bd);
    last_ga = ga;
    last_gb = gb;
  endtask

  // Monitor: whenever the write bus presents a write or a drop, match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (wr_en !== 32'h0 || zero_drop !== 1'b0)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: wr_en=%0h wr_addr=%0d zero_drop=%0b with nothing expected",
                 wr_en, wr_addr, zero_drop);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (wr_en !== e.en || wr_addr !== e.addr || zero_drop !== e.zd ||
            (!e.zd && wr_data !== e.data)) begin
          errors++;
          $display("FAIL write: got en=%0h addr=%0d data=%0h zd=%0b expected en=%0h addr=%0d data=%0h zd=%0b",
                   wr_en, wr_addr, wr_data, zero_drop, e.en, e.addr, e.data, e.zd);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_addr = 5'd0; a_data = 32'h0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 32'h0;
    a_first = 1'b1; last_ga = 1'b0; last_gb = 1'b0;
    #12;
    check("reset_wr_en", wr_en, 32'h0);
    check("reset_wr_addr", wr_addr, 5'd0);
    check("reset_wr_data", wr_data, 32'h0);
    check("reset_zero_drop", zero_drop, 1'b0);

    // requests already pending during the clear must not be granted
    av = 1'b1; aa = 5'd3; ad = 32'hA0000001;
    bv = 1'b1; ba = 5'd7; bd = 32'hB0000001;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_clear();
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #4;
      check("clear_gating", {clearing, a_ready, b_ready}, 3'b100);
    end

    // contended A(3)/B(7): grants alternate starting with A
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (last_ga) ad = $urandom;
      if (last_gb) bd = $urandom;
    end
    bv = 1'b0;
    cyc();
    av = 1'b0;
    cyc();

    // A only, single write then idle
    av = 1'b1; aa = 5'd5; ad = 32'hDEADBEEF;
    cyc();
    av = 1'b0;
    cyc();
    cyc();

    // B targets $0: dropped
    bv = 1'b1; ba = 5'd0; bd = 32'h00001234;
    cyc();
    bv = 1'b0;
    cyc();
    cyc();

    // back-to-back A writes to 1..8
    for (int i = 1; i <= 8; i++) begin
      av = 1'b1; aa = 5'(i); ad = $urandom;
      cyc();
    end
    av = 1'b0;
    cyc();
    cyc();

    // random traffic; a requester holds its request until granted
    for (int n = 0; n < 400; n++) begin
      if (!av || last_ga) begin
        av = ($urandom_range(0, 9) < 6);
        aa = 5'($urandom_range(0, 31));
        ad = $urandom;
      end
      if (!bv || last_gb) begin
        bv = ($urandom_range(0, 9) < 6);
        ba = 5'($urandom_range(0, 31));
        bd = $urandom;
      end
      cyc();
    end
    // drain pending requests
    for (int n = 0; n < 4; n++) begin
      if (last_ga) av = 1'b0;
      if (last_gb) bv = 1'b0;
      cyc();
    end
    av = 1'b0; bv = 1'b0;
    cyc();
    cyc();
    check("drain_empty", sb.size(), 0);

    // reset in the middle of a clear
    @(posedge clk); #2;
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_first = 1'b1;
    push_clear();
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_wr_en", wr_en, 32'h0);
    check("abort_wr_addr", wr_addr, 5'd0);
    check("abort_zero_drop", zero_drop, 1'b0);
    sb.delete();
    a_first = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_clear();
    @(posedge clk); #4;
    check("restart_wr_en", wr_en, 32'h1);
    repeat (33) @(posedge clk);
    #4;
    check("restart_clearing", clearing, 1'b0);
    check("final_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
